press_classifier: RTL and testbench

- Consumes the debounced level from the push-button debouncer and classifies each user gesture as a short press, long press or double press.
- Emits one-cycle event ticks to the control logic downstream, e.g. a mode FSM or a display driver.
- Sits directly after the debouncer on the Nexys A7-100T button path, in the same clock domain.

---
 rtl/press_classifier.sv | 132 +++++++++++++
 tb/tb_press_classifier.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/press_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | press_classifier: turns a debounced button level into short, long and     |
// | double press ticks. Optional PRESS_CLASSIFIER_AUTOREPEAT_EN adds repeat.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module press_classifier #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int GAP_CYCLES    = 25_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic db_level,
    output logic short_tick,
    output logic long_tick,
    output logic double_tick,
    output logic busy
`ifdef PRESS_CLASSIFIER_AUTOREPEAT_EN
    ,
    output logic repeat_tick
`endif
);

    localparam int MAX_LG     = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int MAX_CYCLES = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`ifdef PRESS_CLASSIFIER_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS1   = 3'd1,
        GAP      = 3'd2,
        LONGHOLD = 3'd3,
        WAITREL  = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            short_tick  <= 1'b0;
            long_tick   <= 1'b0;
            double_tick <= 1'b0;
`ifdef PRESS_CLASSIFIER_AUTOREPEAT_EN
            repeat_tick <= 1'b0;
`endif
        end else begin
            short_tick  <= 1'b0;
            long_tick   <= 1'b0;
            double_tick <= 1'b0;
`ifdef PRESS_CLASSIFIER_AUTOREPEAT_EN
            repeat_tick <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (db_level) begin
                        state <= PRESS1;
                        cnt   <= CNT_ONE;
                    end
                end
                PRESS1: begin
                    // A release always wins over the long threshold on the same edge.
                    if (!db_level) begin
                        state <= GAP;
                        cnt   <= CNT_ONE;
                    end else if (cnt == LONG_LAST) begin
                        long_tick <= 1'b1;
                        state     <= LONGHOLD;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                GAP: begin
                    // A re-press always wins over the gap timeout on the same edge.
                    if (db_level) begin
                        double_tick <= 1'b1;
                        state       <= WAITREL;
                        cnt         <= '0;
                    end else if (cnt == GAP_LAST) begin
                        short_tick <= 1'b1;
                        state      <= IDLE;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                LONGHOLD: begin
                    if (!db_level) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
`ifdef PRESS_CLASSIFIER_AUTOREPEAT_EN
                        if (cnt == REP_LAST) begin
                            repeat_tick <= 1'b1;
                            cnt         <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
`else
                        cnt <= cnt;
`endif
                    end
                end
                WAITREL: begin
                    if (!db_level) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_press_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_press_classifier: random and directed gestures against a run-length    |
// | reference model with a tick scoreboard. Revision: 1.0                     |
// +--------------------------------------------------------------------------+
module tb_press_classifier;

    localparam int L = 8;
    localparam int G = 4;
    localparam int R = 3;

    localparam int K_SHORT  = 1;
    localparam int K_LONG   = 2;
    localparam int K_DOUBLE = 3;
    localparam int K_REPEAT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic db_level = 1'b0;
    logic short_tick, long_tick, double_tick, busy;
`ifdef PRESS_CLASSIFIER_AUTOREPEAT_EN
    logic repeat_tick;
`endif

    press_classifier #(
        .LONG_CYCLES  (L),
        .GAP_CYCLES   (G),
        .REPEAT_CYCLES(R)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .db_level   (db_level),
        .short_tick (short_tick),
        .long_tick  (long_tick),
        .double_tick(double_tick),
        .busy       (busy)
`ifdef PRESS_CLASSIFIER_AUTOREPEAT_EN
        ,
        .repeat_tick(repeat_tick)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    bit  db_s[$];
    bit  rst_s[$];
    bit  busy_e[$];
    ev_t exp_q[$];

    int vectors    = 0;
    int miscompares = 0;
    int cur_edge   = -1;
    bit done       = 1'b0;
    int mon_n;
    int rep_now;

    task automatic add(input bit lvl, input int n);
        repeat (n) begin
            db_s.push_back(lvl);
            rst_s.push_back(1'b0);
        end
    endtask

    task automatic add_rst(input bit lvl, input int n);
        repeat (n) begin
            db_s.push_back(lvl);
            rst_s.push_back(1'b1);
        end
    endtask

    task automatic push_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic mark_busy(input int a, input int b);
        for (int k = a; k <= b; k++) busy_e[k] = 1'b1;
    endtask

    // Classifies the samples of one reset-free segment [a,b) by run lengths.
    // Event times are the edge index at which the deciding sample is taken.
    task automatic analyze(input int a, input int b);
        int i, h, r, g, h2;
        i = a;
        while (i < b) begin
            if (!db_s[i]) begin
                i++;
                continue;
            end
            h = 0;
            while (i + h < b && db_s[i + h]) h++;
            if (h >= L) begin
                push_ev(K_LONG, i + L - 1);
`ifdef PRESS_CLASSIFIER_AUTOREPEAT_EN
                for (int e = i + L - 1 + R; e <= i + h - 1; e += R) push_ev(K_REPEAT, e);
`endif
                mark_busy(i, i + h - 1);
                i = i + h;
                continue;
            end
            r = i + h;
            if (r >= b) begin
                mark_busy(i, b - 1);
                break;
            end
            g = 0;
            while (r + g < b && !db_s[r + g]) g++;
            if (g >= G) begin
                push_ev(K_SHORT, r + G - 1);
                mark_busy(i, r + G - 2);
                i = r + G;
                continue;
            end
            if (r + g >= b) begin
                mark_busy(i, b - 1);
                break;
            end
            push_ev(K_DOUBLE, r + g);
            h2 = 0;
            while (r + g + h2 < b && db_s[r + g + h2]) h2++;
            mark_busy(i, r + g + h2 - 1);
            i = r + g + h2;
        end
    endtask

    task automatic check_tick(input int kind);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL tick_unexpected: got kind %0d at edge %0d, required no tick", kind, cur_edge);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.at != cur_edge) begin
                miscompares++;
                $display("FAIL tick: got kind %0d at edge %0d, required kind %0d at edge %0d",
                         kind, cur_edge, e.kind, e.at);
            end
        end
    endtask

    always @(negedge clk) begin
        if (cur_edge >= 0 && !done) begin
            rep_now = 0;
`ifdef PRESS_CLASSIFIER_AUTOREPEAT_EN
            rep_now = int'(repeat_tick);
`endif
            mon_n = int'(short_tick) + int'(long_tick) + int'(double_tick) + rep_now;
            vectors++;
            if (mon_n > 1) begin
                miscompares++;
                $display("FAIL onehot: got %0d ticks at edge %0d, required at most 1", mon_n, cur_edge);
            end
            if (rst_s[cur_edge]) begin
                vectors++;
                if (mon_n != 0 || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_state: got ticks=%0d busy=%b at edge %0d, required 0/0",
                             mon_n, busy, cur_edge);
                end
            end
            vectors++;
            if (busy !== busy_e[cur_edge]) begin
                miscompares++;
                $display("FAIL busy: got %b at edge %0d, required %b", busy, cur_edge, busy_e[cur_edge]);
            end
            if (short_tick)  check_tick(K_SHORT);
            if (long_tick)   check_tick(K_LONG);
            if (double_tick) check_tick(K_DOUBLE);
            if (rep_now != 0) check_tick(K_REPEAT);
        end
    end

    initial begin
        int seg_a;
        add_rst(1'b0, 3);
        add(1'b0, 2);
        // short, long, double
        add(1'b1, 3);  add(1'b0, 10);
        add(1'b1, 20); add(1'b0, 10);
        add(1'b1, 2);  add(1'b0, 2); add(1'b1, 10); add(1'b0, 10);
        // boundaries
        add(1'b1, 7);  add(1'b0, 10);
        add(1'b1, 8);  add(1'b0, 10);
        add(1'b1, 2);  add(1'b0, 3); add(1'b1, 1); add(1'b0, 10);
        add(1'b1, 2);  add(1'b0, 4); add(1'b1, 1); add(1'b0, 10);
        // reset in the gap, then reset while held
        add(1'b1, 3);  add(1'b0, 2); add_rst(1'b0, 1); add(1'b0, 10);
        add(1'b1, 4);  add_rst(1'b1, 1); add(1'b1, 3); add(1'b0, 10);
        // back-to-back shorts
        add(1'b1, 2);  add(1'b0, 5); add(1'b1, 2); add(1'b0, 10);
        for (int n = 0; n < 40; n++) begin
            add(1'b1, int'($urandom_range(1, 22)));
            add(1'b0, int'($urandom_range(1, 7)));
            if ($urandom_range(0, 9) == 0) add_rst(1'($urandom_range(0, 1)), 1);
        end
        add(1'b0, 12);

        for (int k = 0; k < db_s.size(); k++) busy_e.push_back(1'b0);
        seg_a = 0;
        for (int k = 0; k < rst_s.size(); k++) begin
            if (rst_s[k]) begin
                analyze(seg_a, k);
                seg_a = k + 1;
            end
        end
        analyze(seg_a, db_s.size());

        for (int k = 0; k < db_s.size(); k++) begin
            db_level = db_s[k];
            reset    = rst_s[k];
            @(posedge clk);
            #1 cur_edge = k;
        end
        @(negedge clk);
        #1 done = 1'b1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_ticks: got %0d expected ticks never seen, required 0 (next kind %0d at edge %0d)",
                     exp_q.size(), exp_q[0].kind, exp_q[0].at);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
